rope_solver: RTL and testbench

Parametrised, time-multiplexed rope physics engine. Replaces the fixed per-core node chain with one shared relaxation datapath that sweeps a register file of NODES positions, one node per clock. Each requested frame step applies gravity and ITERS Gauss-Seidel neighbour-relaxation passes. The step also supports an optional tail pinned to an anchor point. It sits between the mouse/input logic and the pixel renderer and publishes a consistent 10-bit pixel snapshot per frame.

---
 rtl/rope_pkg.sv | 28 ++
 rtl/rope_relax_unit.sv | 26 ++
 rtl/rope_solver.sv | 102 ++++++++++
 tb/tb_rope_solver.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/rope_pkg.sv
// rope_pkg: FSM encoding and fixed-point helpers shared by the rope solver
package rope_pkg;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LATCH = 3'd1;
  localparam logic [2:0] S_GRAV  = 3'd2;
  localparam logic [2:0] S_RELAX = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam int PIX_BITS = 10;

  // Largest coordinate whose pixel is 1023: (1023<<frac) | (2^frac-1)
  function automatic logic signed [63:0] fx_max(input int frac);
    return (64'sd1 <<< (frac + PIX_BITS)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] pix_to_fx(input logic [9:0] p, input int frac);
    return $signed({54'd0, p}) <<< frac;
  endfunction

  function automatic logic [9:0] fx_to_pix(input logic signed [63:0] v, input int frac);
    logic signed [63:0] t;
    t = v >>> frac;
    return t[9:0];
  endfunction

  function automatic logic signed [63:0] clamp_fx(input logic signed [63:0] v, input int frac);
    return v < 0 ? 64'sd0 : (v > fx_max(frac) ? fx_max(frac) : v);
  endfunction
endpackage

// File: rtl/rope_relax_unit.sv
// rope_relax_unit: one coordinate of the gravity / relaxation update, clamped to screen range
module rope_relax_unit
  import rope_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int FRAC        = 12,
  parameter int STIFF_SHIFT = 2,
  parameter int GRAVITY     = 0
) (
  input  logic signed [WIDTH-1:0] prev_p,
  input  logic signed [WIDTH-1:0] self_p,
  input  logic signed [WIDTH-1:0] next_p,
  input  logic                    is_tail,
  input  logic                    pinned,
  input  logic                    grav,
  output logic signed [WIDTH-1:0] new_p
);
  localparam int W2 = WIDTH + 2;
  logic signed [W2-1:0] p, s, n, tgt, res;
  assign p = W2'(prev_p);
  assign s = W2'(self_p);
  assign n = W2'(next_p);
  assign tgt = is_tail ? p : (p + n) >>> 1;
  assign res = grav ? s + W2'(GRAVITY) : s + ((tgt - s) >>> STIFF_SHIFT);
  assign new_p = pinned ? self_p : WIDTH'(clamp_fx(64'(res), FRAC));
endmodule

// File: rtl/rope_solver.sv
// rope_solver: time-multiplexed rope engine sweeping one node per clock through a shared datapath
module rope_solver
  import rope_pkg::*;
#(
  parameter int NODES       = 20,
  parameter int WIDTH       = 32,
  parameter int FRAC        = 12,
  parameter int ITERS       = 4,
  parameter int STIFF_SHIFT = 2,
  parameter int GRAVITY     = 32'h0000_0200,
  parameter int SPACING     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  step,
  input  logic                  mode_pin_tail,
  input  logic [9:0]            in_mouse_x,
  input  logic [9:0]            in_mouse_y,
  input  logic [9:0]            anchor_x,
  input  logic [9:0]            anchor_y,
  output logic                  busy,
  output logic                  step_done,
  output logic [NODES*10-1:0]   nodes_x,
  output logic [NODES*10-1:0]   nodes_y
);
  localparam int IW = $clog2(NODES);
  localparam int PW = $clog2(ITERS + 1);
  localparam logic [IW-1:0] LAST = IW'(NODES - 1);
  logic [2:0] state, nstate;
  logic [IW-1:0] idx, nidx;
  logic [PW-1:0] pass;
  logic pin_q, is_tail, pinned, grav;
  logic signed [WIDTH-1:0] px [NODES];
  logic signed [WIDTH-1:0] py [NODES];
  logic signed [WIDTH-1:0] nx, ny;
  assign is_tail = idx == LAST;
  assign pinned = pin_q && is_tail;
  assign grav = state == S_GRAV;
  // idx stays in 1..LAST, so idx-1 is always valid; the tail reuses itself as its successor
  assign nidx = is_tail ? idx : idx + 1'b1;
  rope_relax_unit #(.WIDTH(WIDTH), .FRAC(FRAC), .STIFF_SHIFT(STIFF_SHIFT), .GRAVITY(0)) u_x (
    .prev_p(px[idx - 1'b1]), .self_p(px[idx]), .next_p(px[nidx]),
    .is_tail(is_tail), .pinned(pinned), .grav(grav), .new_p(nx)
  );
  rope_relax_unit #(.WIDTH(WIDTH), .FRAC(FRAC), .STIFF_SHIFT(STIFF_SHIFT), .GRAVITY(GRAVITY)) u_y (
    .prev_p(py[idx - 1'b1]), .self_p(py[idx]), .next_p(py[nidx]),
    .is_tail(is_tail), .pinned(pinned), .grav(grav), .new_p(ny)
  );
  always_comb begin
    nstate = S_IDLE;
    case (state)
      S_IDLE:  nstate = step ? S_LATCH : S_IDLE;
      S_LATCH: nstate = S_GRAV;
      S_GRAV:  nstate = is_tail ? S_RELAX : S_GRAV;
      S_RELAX: nstate = (is_tail && pass == PW'(ITERS - 1)) ? S_DONE : S_RELAX;
      default: nstate = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      busy <= 1'b0;
      step_done <= 1'b0;
      idx <= IW'(1);
      pass <= '0;
      pin_q <= 1'b0;
      for (int k = 0; k < NODES; k++) begin
        px[k] <= WIDTH'(pix_to_fx(10'(SPACING * k), FRAC));
        py[k] <= '0;
        nodes_x[k*10 +: 10] <= 10'(SPACING * k);
        nodes_y[k*10 +: 10] <= '0;
      end
    end else begin
      state <= nstate;
      busy <= nstate != S_IDLE;
      step_done <= nstate == S_DONE;
      if (state == S_LATCH) begin
        pin_q <= mode_pin_tail;
        idx <= IW'(1);
        pass <= '0;
        px[0] <= WIDTH'(pix_to_fx(in_mouse_x, FRAC));
        py[0] <= WIDTH'(pix_to_fx(in_mouse_y, FRAC));
        if (mode_pin_tail) begin
          px[NODES-1] <= WIDTH'(pix_to_fx(anchor_x, FRAC));
          py[NODES-1] <= WIDTH'(pix_to_fx(anchor_y, FRAC));
        end
      end
      if (state == S_GRAV || state == S_RELAX) begin
        px[idx] <= nx;
        py[idx] <= ny;
        idx <= is_tail ? IW'(1) : idx + 1'b1;
        if (state == S_RELAX && is_tail) pass <= pass + 1'b1;
      end
      if (state == S_DONE) begin
        for (int k = 0; k < NODES; k++) begin
          nodes_x[k*10 +: 10] <= fx_to_pix(64'(px[k]), FRAC);
          nodes_y[k*10 +: 10] <= fx_to_pix(64'(py[k]), FRAC);
        end
      end
    end
  end
endmodule

// File: tb/tb_rope_solver.sv
// tb_rope_solver: directed checks of timing, relaxation maths, pinning, reset and clamping
module tb_rope_solver;
  logic clk, reset, step_m, step_s, step_c, mode;
  logic [9:0] mx, my, ax, ay;
  logic busy_m, done_m, busy_s, done_s, busy_c, done_c;
  logic [199:0] nx_m, ny_m;
  logic [29:0] nx_s, ny_s;
  logic [39:0] nx_c, ny_c;
  int checks = 0;
  int errors = 0;

  rope_solver u_dut (
    .clk(clk), .reset(reset), .step(step_m), .mode_pin_tail(mode),
    .in_mouse_x(mx), .in_mouse_y(my), .anchor_x(ax), .anchor_y(ay),
    .busy(busy_m), .step_done(done_m), .nodes_x(nx_m), .nodes_y(ny_m)
  );
  // 3 nodes, 1 pass, 8 px gravity: small enough to work out by hand
  rope_solver #(.NODES(3), .ITERS(1), .GRAVITY(32768)) u_small (
    .clk(clk), .reset(reset), .step(step_s), .mode_pin_tail(mode),
    .in_mouse_x(mx), .in_mouse_y(my), .anchor_x(ax), .anchor_y(ay),
    .busy(busy_s), .step_done(done_s), .nodes_x(nx_s), .nodes_y(ny_s)
  );
  rope_solver #(.NODES(4), .ITERS(4), .GRAVITY(0)) u_conv (
    .clk(clk), .reset(reset), .step(step_c), .mode_pin_tail(mode),
    .in_mouse_x(mx), .in_mouse_y(my), .anchor_x(ax), .anchor_y(ay),
    .busy(busy_c), .step_done(done_c), .nodes_x(nx_c), .nodes_y(ny_c)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic run_step(input int which);
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    if (which == 0) step_m = 1; else if (which == 1) step_s = 1; else step_c = 1;
    @(negedge clk);
    step_m = 0; step_s = 0; step_c = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      seen = which == 0 ? done_m : (which == 1 ? done_s : done_c);
      if (!seen) @(negedge clk);
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL step_timeout unit %0d: no step_done within 200 cycles, required one", which);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 0;
    repeat (2) @(negedge clk);
    reset = 1;
    @(negedge clk);
    checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_m); end
    checks++; if (done_m !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done_m); end
    for (int k = 0; k < 20; k++) begin
      checks++; if (nx_m[k*10 +: 10] !== 10'(8*k)) begin errors++; $display("FAIL reset_x[%0d]: got %0d expected %0d", k, nx_m[k*10 +: 10], 8*k); end
      checks++; if (ny_m[k*10 +: 10] !== 10'd0) begin errors++; $display("FAIL reset_y[%0d]: got %0d expected 0", k, ny_m[k*10 +: 10]); end
    end
    checks++; if (nx_s !== {10'd16, 10'd8, 10'd0}) begin errors++; $display("FAIL reset_small_x: got %h expected %h", nx_s, {10'd16, 10'd8, 10'd0}); end
  endtask

  task automatic test_single_step;
    mx = 100; my = 50; mode = 0;
    @(negedge clk);
    step_m = 1;
    @(posedge clk);
    for (int k = 1; k <= 98; k++) begin
      @(negedge clk);
      step_m = 0;
      checks++; if (busy_m !== (k <= 97)) begin errors++; $display("FAIL single_busy cycle %0d: got %b expected %b", k, busy_m, k <= 97); end
      checks++; if (done_m !== (k == 97)) begin errors++; $display("FAIL single_done cycle %0d: got %b expected %b", k, done_m, k == 97); end
      if (k == 50) begin
        checks++; if (nx_m[190 +: 10] !== 10'd152) begin errors++; $display("FAIL single_hold_tail: got %0d expected 152", nx_m[190 +: 10]); end
      end
      if (k == 97) begin
        checks++; if ({nx_m[9:0], ny_m[9:0]} !== {10'd0, 10'd0}) begin errors++; $display("FAIL single_head_early: got (%0d,%0d) expected (0,0)", nx_m[9:0], ny_m[9:0]); end
      end
      if (k == 98) begin
        checks++; if ({nx_m[9:0], ny_m[9:0]} !== {10'd100, 10'd50}) begin errors++; $display("FAIL single_head: got (%0d,%0d) expected (100,50)", nx_m[9:0], ny_m[9:0]); end
      end
    end
  endtask

  task automatic test_small_exact;
    int ex1[3] = '{0, 8, 14};
    int ey1[3] = '{0, 7, 7};
    int ex2[3] = '{40, 12, 13};
    int ey2[3] = '{0, 13, 15};
    mx = 0; my = 0; mode = 0;
    run_step(1);
    for (int k = 0; k < 3; k++) begin
      checks++; if (nx_s[k*10 +: 10] !== 10'(ex1[k])) begin errors++; $display("FAIL small1_x[%0d]: got %0d expected %0d", k, nx_s[k*10 +: 10], ex1[k]); end
      checks++; if (ny_s[k*10 +: 10] !== 10'(ey1[k])) begin errors++; $display("FAIL small1_y[%0d]: got %0d expected %0d", k, ny_s[k*10 +: 10], ey1[k]); end
    end
    mx = 40;
    run_step(1);
    for (int k = 0; k < 3; k++) begin
      checks++; if (nx_s[k*10 +: 10] !== 10'(ex2[k])) begin errors++; $display("FAIL small2_x[%0d]: got %0d expected %0d", k, nx_s[k*10 +: 10], ex2[k]); end
      checks++; if (ny_s[k*10 +: 10] !== 10'(ey2[k])) begin errors++; $display("FAIL small2_y[%0d]: got %0d expected %0d", k, ny_s[k*10 +: 10], ey2[k]); end
    end
  endtask

  task automatic test_pinned;
    logic seen;
    mode = 1; ax = 500; ay = 300; mx = 100; my = 100;
    @(negedge clk);
    step_m = 1;
    @(negedge clk);
    step_m = 0;
    seen = 1'b0;
    for (int k = 1; k < 200 && !seen; k++) begin
      seen = done_m;
      if (k == 40) begin mx = 300; my = 300; mode = 0; ax = 7; ay = 9; end
      if (!seen) @(negedge clk);
    end
    checks++; if (!seen) begin errors++; $display("FAIL pin_timeout: step_done got 0 expected 1"); end
    @(negedge clk);
    checks++; if ({nx_m[190 +: 10], ny_m[190 +: 10]} !== {10'd500, 10'd300}) begin errors++; $display("FAIL pin_tail1: got (%0d,%0d) expected (500,300)", nx_m[190 +: 10], ny_m[190 +: 10]); end
    checks++; if ({nx_m[9:0], ny_m[9:0]} !== {10'd100, 10'd100}) begin errors++; $display("FAIL pin_head1: got (%0d,%0d) expected (100,100)", nx_m[9:0], ny_m[9:0]); end
    mode = 1; ax = 500; ay = 300;
    run_step(0);
    checks++; if ({nx_m[190 +: 10], ny_m[190 +: 10]} !== {10'd500, 10'd300}) begin errors++; $display("FAIL pin_tail2: got (%0d,%0d) expected (500,300)", nx_m[190 +: 10], ny_m[190 +: 10]); end
    checks++; if ({nx_m[9:0], ny_m[9:0]} !== {10'd300, 10'd300}) begin errors++; $display("FAIL pin_head2: got (%0d,%0d) expected (300,300)", nx_m[9:0], ny_m[9:0]); end
    mode = 0;
  endtask

  task automatic test_back_to_back;
    int hits[$];
    @(negedge clk);
    step_m = 1;
    @(posedge clk);
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (done_m) hits.push_back(k);
      if (k == 294) step_m = 0;
    end
    checks++; if (hits.size() != 3) begin errors++; $display("FAIL b2b_count: got %0d pulses expected 3", hits.size()); end
    else begin
      checks++; if (hits[0] != 97) begin errors++; $display("FAIL b2b_first: got cycle %0d expected 97", hits[0]); end
      checks++; if (hits[1] != 195) begin errors++; $display("FAIL b2b_second: got cycle %0d expected 195", hits[1]); end
      checks++; if (hits[2] != 293) begin errors++; $display("FAIL b2b_third: got cycle %0d expected 293", hits[2]); end
    end
    checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL b2b_idle: busy got %b expected 0", busy_m); end
  endtask

  task automatic test_mid_reset;
    int ndone;
    ndone = 0;
    mode = 1; ax = 500; ay = 300;
    run_step(0);
    mode = 0;
    @(negedge clk);
    step_m = 1;
    @(posedge clk);
    for (int k = 1; k <= 140; k++) begin
      @(negedge clk);
      step_m = 0;
      if (done_m) ndone++;
      if (k == 40) reset = 0;
      if (k == 41) begin
        reset = 1;
        checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy_m); end
        for (int j = 0; j < 20; j++) begin
          checks++; if ({nx_m[j*10 +: 10], ny_m[j*10 +: 10]} !== {10'(8*j), 10'd0}) begin errors++; $display("FAIL midrst_node[%0d]: got (%0d,%0d) expected (%0d,0)", j, nx_m[j*10 +: 10], ny_m[j*10 +: 10], 8*j); end
        end
      end
    end
    checks++; if (ndone != 0) begin errors++; $display("FAIL midrst_done: got %0d pulses expected 0", ndone); end
  endtask

  task automatic test_convergence;
    int d;
    mx = 200; my = 200; mode = 0;
    repeat (200) run_step(2);
    for (int k = 0; k < 4; k++) begin
      d = int'(nx_c[k*10 +: 10]) - 200;
      checks++; if (d < -1 || d > 1) begin errors++; $display("FAIL conv_x[%0d]: got %0d expected 200+-1", k, nx_c[k*10 +: 10]); end
      d = int'(ny_c[k*10 +: 10]) - 200;
      checks++; if (d < -1 || d > 1) begin errors++; $display("FAIL conv_y[%0d]: got %0d expected 200+-1", k, ny_c[k*10 +: 10]); end
    end
  endtask

  task automatic test_clamp;
    mx = 1023; my = 1023; mode = 0;
    repeat (150) run_step(1);
    for (int k = 0; k < 3; k++) begin
      checks++; if (ny_s[k*10 +: 10] !== 10'd1023) begin errors++; $display("FAIL clamp_small_y[%0d]: got %0d expected 1023", k, ny_s[k*10 +: 10]); end
      checks++; if (nx_s[k*10 +: 10] < 10'd1022) begin errors++; $display("FAIL clamp_small_x[%0d]: got %0d expected >=1022", k, nx_s[k*10 +: 10]); end
    end
    repeat (3) run_step(0);
    checks++; if ({nx_m[9:0], ny_m[9:0]} !== {10'd1023, 10'd1023}) begin errors++; $display("FAIL clamp_head: got (%0d,%0d) expected (1023,1023)", nx_m[9:0], ny_m[9:0]); end
  endtask

  initial begin
    reset = 0; step_m = 0; step_s = 0; step_c = 0; mode = 0;
    mx = 0; my = 0; ax = 0; ay = 0;
    test_reset();
    test_single_step();
    test_small_exact();
    test_pinned();
    test_back_to_back();
    test_mid_reset();
    test_convergence();
    test_clamp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
